// File: rtl/keypad4x4_scan.sv
// keypad4x4_scan: 4x4 active-low matrix keypad scanner with frame debounce and a valid/ack key queue.
// Latency: the key code is valid on the clock edge after the closing tick of the DEBOUNCE_N-th matching frame.
// Backpressure: one code is held until acked; a press arriving while a code is pending is dropped and o_overflow is set.
//
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   i_col[3:0]    column lines, active-low, asynchronous (2-flop synchronized here)
//   i_key_ack     consumer acknowledge, level-sampled
//   o_row[3:0]    row drive, active-low one-hot
//   o_key_code    {row[1:0], col[1:0]} of the pending key
//   o_key_valid   a key code is pending
//   o_key_down    a debounced key is currently held
//   o_overflow    a press was dropped while a code was pending
//
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat while a key is held
// (first repeat after REPEAT_DELAY frames, then every REPEAT_RATE frames).
module keypad4x4_scan #(
  parameter int SCAN_DIV_W   = 15,
  parameter int DEBOUNCE_N   = 4,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] i_col,
  input  logic       i_key_ack,
  output logic [3:0] o_row,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_down,
  output logic       o_overflow
);

  // Parameter sanity: the debounce counter is 4 bits wide, repeat intervals must be non-zero.
  if (DEBOUNCE_N < 1 || DEBOUNCE_N > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("keypad4x4_scan: parameter out of range");
  end

  localparam logic [3:0] DBN = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  logic [3:0]            col_s1, col_s2;
  logic [SCAN_DIV_W-1:0] presc;
  logic [1:0]            row_idx;
  logic [11:0]           frame_acc;   // low columns of rows 0..2 of the current frame
  logic                  tick;
  logic                  frame_close;
  logic [3:0]            row_low;
  logic [15:0]           frame_now;
  logic [4:0]            n_low;
  logic [3:0]            code_f;
  logic                  is_none, is_single, is_multi;

  state_t                state, state_nx;
  logic [3:0]            cand, cand_nx;
  logic [3:0]            cnt, cnt_nx, cnt_inc;
  logic                  emit, start_new;
  logic                  rep_hit;

  // ---------------- column synchronizer ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= i_col;
      col_s2 <= col_s1;
    end
  end

  // ---------------- prescaler, row scan, frame capture ----------------
  assign tick        = &presc;
  assign frame_close = tick && (row_idx == 2'd3);
  assign row_low     = ~col_s2;
  assign o_row       = ~(4'b0001 << row_idx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc     <= '0;
      row_idx   <= 2'd0;
      frame_acc <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (tick) begin
        row_idx <= row_idx + 2'd1;
        case (row_idx)
          2'd0:    frame_acc[3:0]  <= row_low;
          2'd1:    frame_acc[7:4]  <= row_low;
          2'd2:    frame_acc[11:8] <= row_low;
          default: frame_acc       <= '0;   // row 3 closes the frame; start the next one clean
        endcase
      end
    end
  end

  // Row 3 is classified straight from the synchronizer on the closing tick.
  assign frame_now = {row_low, frame_acc};

  always_comb begin
    n_low  = '0;
    code_f = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_now[i]) begin
        n_low  = n_low + 5'd1;
        code_f = 4'(i);
      end
    end
  end

  assign is_none   = (n_low == 5'd0);
  assign is_single = (n_low == 5'd1);
  assign is_multi  = !is_none && !is_single;

  // ---------------- auto-repeat ----------------
`ifdef KEYPAD_REPEAT_EN
  localparam logic [7:0] REP_DLY  = 8'(REPEAT_DELAY);
  localparam logic [7:0] REP_RATE = 8'(REPEAT_RATE);

  logic [7:0] rep_cnt;
  logic       rep_first;

  assign rep_hit = (rep_cnt + 8'd1) >= (rep_first ? REP_DLY : REP_RATE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (frame_close && !is_multi) begin
      if (state_nx == ST_HELD && state != ST_HELD) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (state == ST_HELD && is_single && code_f == cand) begin
        if (rep_hit) begin
          rep_cnt   <= '0;
          rep_first <= 1'b0;
        end else begin
          rep_cnt <= rep_cnt + 8'd1;
        end
      end
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  // ---------------- debounce FSM ----------------
  assign cnt_inc = cnt + 4'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    cnt_nx    = cnt;
    emit      = 1'b0;
    start_new = 1'b0;
    // MULTI frames are ambiguous (ghosting / two fingers) and change nothing.
    if (frame_close && !is_multi) begin
      case (state)
        ST_IDLE: begin
          if (is_single) start_new = 1'b1;
        end
        ST_DEBOUNCE: begin
          if (is_none) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end else if (code_f == cand) begin
            cnt_nx = cnt_inc;
            if (cnt_inc >= DBN) begin
              emit     = 1'b1;
              state_nx = ST_HELD;
            end
          end else begin
            start_new = 1'b1;
          end
        end
        ST_HELD: begin
          if (is_none) begin
            if (DBN <= 4'd1) begin
              state_nx = ST_IDLE;
              cnt_nx   = '0;
            end else begin
              state_nx = ST_RELEASE;
              cnt_nx   = 4'd1;
            end
          end else if (code_f == cand) begin
            if (rep_hit) emit = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (is_none) begin
            if (cnt_inc >= DBN) begin
              state_nx = ST_IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else if (code_f == cand) begin
            state_nx = ST_HELD;   // bounce during release: same key, no new press
          end else begin
            start_new = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
      // A new candidate key; with a one-frame debounce it is accepted immediately.
      if (start_new) begin
        cand_nx = code_f;
        cnt_nx  = 4'd1;
        if (DBN <= 4'd1) begin
          emit     = 1'b1;
          state_nx = ST_HELD;
        end else begin
          state_nx = ST_DEBOUNCE;
        end
      end
    end
  end

  assign o_key_down = (state == ST_HELD) || (state == ST_RELEASE);

  // ---------------- output slot ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_key_code  <= '0;
      o_key_valid <= 1'b0;
      o_overflow  <= 1'b0;
    end else if (emit) begin
      if (!o_key_valid || i_key_ack) begin
        o_key_code  <= cand_nx;
        o_key_valid <= 1'b1;
        o_overflow  <= 1'b0;
      end else begin
        o_overflow <= 1'b1;
      end
    end else if (i_key_ack && o_key_valid) begin
      o_key_valid <= 1'b0;
      o_overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad4x4_scan.sv
// tb_keypad4x4_scan: directed bench for keypad4x4_scan with a 16-clock frame and 3-frame debounce.
// A behavioural keypad pulls column lines low for every pressed key on the driven row.
// Timing is tracked as clock edges since reset release; frame k closes on edge 16*k.
module tb_keypad4x4_scan;

  logic       clk;
  logic       rstn;
  logic [3:0] i_col;
  logic       i_key_ack;
  logic [3:0] o_row;
  logic [3:0] o_key_code;
  logic       o_key_valid;
  logic       o_key_down;
  logic       o_overflow;

  logic [15:0] keys;   // bit {row,col} set = key pressed
  int          cyc;
  int          n_checks;
  int          n_errors;

  keypad4x4_scan #(
    .SCAN_DIV_W  (2),
    .DEBOUNCE_N  (3),
    .REPEAT_DELAY(4),
    .REPEAT_RATE (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_col      (i_col),
    .i_key_ack  (i_key_ack),
    .o_row      (o_row),
    .o_key_code (o_key_code),
    .o_key_valid(o_key_valid),
    .o_key_down (o_key_down),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    i_col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !o_row[r]) i_col[c] = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Return #1 after clock edge n (counted from reset release).
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [15:0] k);
    rstn      = 1'b0;
    i_key_ack = 1'b0;
    keys      = k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic ack_pulse(input int at_edge);
    i_key_ack = 1'b1;
    wait_edge(at_edge);
    i_key_ack = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    keys      = '0;
    i_key_ack = 1'b0;
    rstn      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_row",   o_row,          4'b1110);
    check("rst_code",  o_key_code,     4'h0);
    check("rst_valid", 4'(o_key_valid), 4'd0);
    check("rst_down",  4'(o_key_down),  4'd0);
    check("rst_ovf",   4'(o_overflow),  4'd0);

    // Reset in the middle of debouncing key 0x9 must discard the progress.
    do_reset(16'h0200);
    wait_edge(32);
    check("t1_mid_valid", 4'(o_key_valid), 4'd0);
    do_reset(16'h0200);
    wait_edge(4);
    check("t1_row1", o_row, 4'b1101);
    wait_edge(16);
    check("t1_row_wrap", o_row, 4'b1110);
    check("t1_f1_valid", 4'(o_key_valid), 4'd0);
    wait_edge(47);
    check("t1_pre_valid", 4'(o_key_valid), 4'd0);
    check("t1_pre_down",  4'(o_key_down),  4'd0);
    wait_edge(48);
    check("t1_valid", 4'(o_key_valid), 4'd1);
    check("t1_code",  o_key_code,      4'h9);
    check("t1_down",  4'(o_key_down),   4'd1);
    wait_edge(96);
    check("t1_one_press_ovf", 4'(o_overflow), 4'd0);
    check("t1_hold_code",     o_key_code,     4'h9);

    // Bounce: present 2 frames, absent 1, present 3.
    do_reset(16'h0040);
    wait_edge(32);
    keys = 16'h0000;
    wait_edge(48);
    keys = 16'h0040;
    wait_edge(95);
    check("t2_pre_valid", 4'(o_key_valid), 4'd0);
    wait_edge(96);
    check("t2_valid", 4'(o_key_valid), 4'd1);
    check("t2_code",  o_key_code,      4'h6);
    wait_edge(144);
    check("t2_ovf", 4'(o_overflow), 4'd0);

    // Two keys together: ignored; a MULTI frame inside a debounce keeps the count.
    do_reset(16'h0021);
    wait_edge(96);
    check("t3_multi_valid", 4'(o_key_valid), 4'd0);
    check("t3_multi_down",  4'(o_key_down),  4'd0);
    keys = 16'h0001;
    wait_edge(128);
    keys = 16'h0021;
    wait_edge(144);
    check("t3_gap_valid", 4'(o_key_valid), 4'd0);
    keys = 16'h0001;
    wait_edge(160);
    check("t3_valid", 4'(o_key_valid), 4'd1);
    check("t3_code",  o_key_code,      4'h0);

    // Overflow, ack-on-emit, ack clearing.
    do_reset(16'h0002);
    wait_edge(48);
    check("t4_code1", o_key_code, 4'h1);
    keys = 16'h0000;
    wait_edge(95);
    check("t4_rel_down", 4'(o_key_down), 4'd1);
    wait_edge(96);
    check("t4_up_down", 4'(o_key_down), 4'd0);
    keys = 16'h0020;
    wait_edge(144);
    check("t4_ovf_code",  o_key_code,      4'h1);
    check("t4_ovf_valid", 4'(o_key_valid), 4'd1);
    check("t4_ovf",       4'(o_overflow),  4'd1);
    check("t4_ovf_down",  4'(o_key_down),  4'd1);
    keys = 16'h0000;
    wait_edge(192);
    keys = 16'h1000;
    wait_edge(239);
    ack_pulse(240);
    check("t5_valid", 4'(o_key_valid), 4'd1);
    check("t5_code",  o_key_code,      4'hC);
    check("t5_ovf",   4'(o_overflow),  4'd0);
    keys = 16'h0000;
    wait_edge(288);
    keys = 16'h0001;
    wait_edge(336);
    check("t5b_ovf",  4'(o_overflow), 4'd1);
    check("t5b_code", o_key_code,     4'hC);
    ack_pulse(337);
    check("t5b_ack_valid", 4'(o_key_valid), 4'd0);
    check("t5b_ack_ovf",   4'(o_overflow),  4'd0);

    // Hold 0x3 with acks: repeats only when auto-repeat is built in.
    do_reset(16'h0008);
    wait_edge(48);
    check("t6_valid0", 4'(o_key_valid), 4'd1);
    check("t6_code0",  o_key_code,      4'h3);
    ack_pulse(49);
    check("t6_ack0", 4'(o_key_valid), 4'd0);
    wait_edge(111);
    check("t6_pre1", 4'(o_key_valid), 4'd0);
    wait_edge(112);
`ifdef KEYPAD_REPEAT_EN
    check("t6_rep1_valid", 4'(o_key_valid), 4'd1);
    check("t6_rep1_code",  o_key_code,      4'h3);
`else
    check("t6_norep1_valid", 4'(o_key_valid), 4'd0);
`endif
    ack_pulse(113);
    wait_edge(143);
    check("t6_pre2", 4'(o_key_valid), 4'd0);
    wait_edge(144);
`ifdef KEYPAD_REPEAT_EN
    check("t6_rep2_valid", 4'(o_key_valid), 4'd1);
`else
    check("t6_norep2_valid", 4'(o_key_valid), 4'd0);
`endif
    ack_pulse(145);
    keys = 16'h0000;
    wait_edge(191);
    check("t6_rel_down", 4'(o_key_down), 4'd1);
    wait_edge(192);
    check("t6_up_down", 4'(o_key_down), 4'd0);
    check("t6_ovf",     4'(o_overflow), 4'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
